reg_bank_writeback: RTL and testbench

- Consumer end of the register-file write-data select path: the 32-bit value chosen by the writeback data mux is captured here.
- Sources for that value: PC, ALU result, constant 227, LT-extend, HI, LO, load-size output, shifter output.
- 32x32 general-purpose register bank for the multicycle MIPS datapath: one synchronous write port, two combinational read ports.
- Register 0 is hardwired to zero; the stack pointer (reg 29) resets to 227.

---
 rtl/reg_bank_writeback_pkg.sv | 26 ++
 rtl/reg_bank_writeback.sv | 49 ++++
 tb/tb_reg_bank_writeback.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/reg_bank_writeback_pkg.sv
// Shared datapath constants for the register bank and the writeback select mux.
// The stack-pointer reset constant is defined once here and used by both.
package reg_bank_writeback_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int SP_INDEX  = 29;

    // The writeback mux drives this same constant when its select is WB_SEL_CONST.
    localparam logic [DATA_W-1:0] SP_RESET     = 32'd227;
    localparam logic [3:0]        WB_SEL_CONST = 4'b0010;

    // Architectural register names. The control unit uses RA as the jal link target.
    typedef enum logic [REG_IDX_W-1:0] {
        ZERO = 5'd0,
        SP   = 5'd29,
        RA   = 5'd31
    } reg_name_e;

    function automatic logic [DATA_W-1:0] reset_value(input int unsigned idx,
                                                      input int unsigned sp_idx,
                                                      input logic [DATA_W-1:0] sp_val);
        return (idx == sp_idx) ? sp_val : '0;
    endfunction

endpackage

// File: rtl/reg_bank_writeback.sv
// Multicycle MIPS general-purpose register bank: one synchronous write port and
// two combinational read ports. Register 0 reads as zero; SP resets to SP_RESET.
module reg_bank_writeback
    import reg_bank_writeback_pkg::*;
#(
    parameter int                NUM_REGS = 32,
    parameter int                SP_INDEX = reg_bank_writeback_pkg::SP_INDEX,
    parameter logic [DATA_W-1:0] SP_RESET = reg_bank_writeback_pkg::SP_RESET
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reg_write,
    input  logic [REG_IDX_W-1:0] write_reg,
    input  logic [DATA_W-1:0]    write_data,
    input  logic [REG_IDX_W-1:0] read_reg1,
    input  logic [REG_IDX_W-1:0] read_reg2,
    output logic [DATA_W-1:0]    read_data1,
    output logic [DATA_W-1:0]    read_data2
);

    logic [DATA_W-1:0] w_regs [NUM_REGS];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == 0) begin : g_zero
            // No storage for register 0, so no write can ever make it nonzero.
            assign w_regs[g] = '0;
        end else begin : g_flop
            logic [DATA_W-1:0] r_q;
            logic              w_we;

            assign w_we = reg_write && (write_reg == REG_IDX_W'(g));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= reset_value(g, SP_INDEX, SP_RESET);
                end else if (w_we) begin
                    r_q <= write_data;
                end
            end

            assign w_regs[g] = r_q;
        end
    end

    // Reads come straight from storage: a same-cycle write is visible only after the edge.
    assign read_data1 = w_regs[read_reg1];
    assign read_data2 = w_regs[read_reg2];

endmodule

// File: tb/tb_reg_bank_writeback.sv
// Directed bench for reg_bank_writeback: expected reads are queued as stimulus is
// applied and popped against the read ports once the DUT state has settled.
module tb_reg_bank_writeback;
    import reg_bank_writeback_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        int          port;
        logic [4:0]  idx;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] model [32];

    reg_bank_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
    endtask

    task automatic push(input string tag, input int port, input logic [4:0] idx,
                        input logic [31:0] exp);
        sb_t e;
        e.tag = tag; e.port = port; e.idx = idx; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic push_sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            push(tag, 1, 5'(i), model[i]);
            push(tag, 2, 5'(i), model[i]);
        end
    endtask

    // Pops every queued expectation, steering the relevant read port to its index.
    task automatic drain();
        sb_t         e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.port == 1) read_reg1 = e.idx; else read_reg2 = e.idx;
            #1;
            obs = (e.port == 1) ? read_data1 : read_data2;
            tests++;
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s port%0d reg%0d: got %h expected %h",
                       e.tag, e.port, e.idx, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset image on both ports.
        @(negedge clk);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        push_sweep("reset_sweep");
        drain();

        // Write to reg 8: old value while pending, new value after the edge.
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
        push("write_pending", 1, 5'd8, 32'h0);
        drain();
        tick();
        reg_write = 1'b0;
        model[8] = 32'hDEADBEEF;
        push("write_visible", 1, 5'd8, 32'hDEADBEEF);
        drain();

        // Write to reg 0 is dropped; nothing else moves.
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
        tick();
        reg_write = 1'b0;
        push_sweep("reg0_write");
        drain();

        // Reset beats a same-edge write to SP.
        @(negedge clk);
        reset = 1'b1; reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h1234;
        tick();
        reset = 1'b0; reg_write = 1'b0;
        model_reset();
        push("reset_prio_sp", 1, 5'd29, 32'd227);
        push("reset_prio_r8", 2, 5'd8, 32'd0);
        drain();
        read_reg1 = 5'd29;
        #1;
        tests++;
        assert (read_data1 !== 32'h1234) else begin
            fails++;
            $error("FAIL reset_prio_nowrite: got %h expected not %h", read_data1, 32'h1234);
        end

        // Load regs 1..31 with their index, then hold with write disabled.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            reg_write = 1'b1; write_reg = 5'(i); write_data = 32'(i);
            tick();
            model[i] = 32'(i);
        end
        reg_write = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            write_reg = 5'($urandom_range(0, 31));
            write_data = $urandom();
            tick();
        end
        push_sweep("hold_sweep");
        drain();

        // Back-to-back writes to RA observed on port 2.
        @(negedge clk);
        read_reg2 = 5'd31;
        reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h0000_00E3;
        tick();
        push("b2b_first", 2, 5'd31, 32'h0000_00E3);
        drain();
        @(negedge clk);
        write_data = 32'h0000_0010;
        tick();
        reg_write = 1'b0;
        push("b2b_second", 2, 5'd31, 32'h0000_0010);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
